foo_pipeline_elastic: RTL

Parametrised successor to the two-stage valid-only `foo` pipeline. It chains `NUM_STAGES` combinational stages with alternating `+1` / `+2` stage operations across a configurable datapath width. It adds full valid/ready backpressure, so any rank can stall without losing or duplicating data, and exposes output valid and a busy flag. It sits between a producer and a consumer that both use valid/ready handshakes.

---
 rtl/foo_pipeline_pkg.sv | 17 +
 rtl/foo_pipeline_stage.sv | 24 ++
 rtl/foo_pipeline_elastic.sv | 79 +++++++
 3 files changed

// File: rtl/foo_pipeline_pkg.sv
// Shared constants and helpers for the elastic +1/+2 pipeline.
package foo_pipeline_pkg;

  // Deepest pipeline the block is built and checked for.
  localparam int unsigned FOO_MAX_STAGES = 8;

  // Increment applied by stage i: even stages add 1, odd stages add 2.
  function automatic int unsigned foo_stage_incr(int unsigned i);
    return ((i % 2) == 0) ? 32'd1 : 32'd2;
  endfunction

  // End-to-end result of an n-stage pipeline. The caller truncates to its width.
  function automatic logic [63:0] foo_expected(logic [63:0] x, int unsigned n);
    return x + 64'(n) + 64'(n / 2);
  endfunction

endpackage

// File: rtl/foo_pipeline_stage.sv
// One combinational stage: +1 on even indices, +2 (via the upper bits) on odd.
module foo_pipeline_stage
  import foo_pipeline_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned STAGE_IDX = 0
) (
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] d_o
);

  if (foo_stage_incr(STAGE_IDX) == 1) begin : g_even
    // Plain increment; carry out of the top bit is dropped.
    always_comb begin
      d_o = d_i + WIDTH'(1);
    end
  end else begin : g_odd
    // Bit 0 passes through, so adding 1 above it is the same as adding 2.
    always_comb begin
      d_o = {d_i[WIDTH-1:1] + (WIDTH-1)'(1), d_i[0]};
    end
  end

endmodule

// File: rtl/foo_pipeline_elastic.sv
// Elastic pipeline of NUM_STAGES +1/+2 stages with NUM_STAGES+1 valid/ready register ranks.
module foo_pipeline_elastic
  import foo_pipeline_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             input_valid,
  output logic             input_ready,
  input  logic [WIDTH-1:0] x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  logic [NUM_STAGES:0] rank_valid;
  logic [NUM_STAGES:0] rdy;
  logic [WIDTH-1:0]    rank_data [NUM_STAGES+1];
  logic [WIDTH-1:0]    stage_out [NUM_STAGES];

  // Ready chain: a rank can take new data if it is empty or its successor is taking its item.
  always_comb begin
    rdy             = '0;
    rdy[NUM_STAGES] = out_ready | ~rank_valid[NUM_STAGES];
    for (int r = int'(NUM_STAGES) - 1; r >= 0; r--) begin
      rdy[r] = ~rank_valid[r] | rdy[r+1];
    end
  end

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    foo_pipeline_stage #(
      .WIDTH    (WIDTH),
      .STAGE_IDX(i)
    ) u_stage (
      .d_i(rank_data[i]),
      .d_o(stage_out[i])
    );
  end

  for (genvar r = 0; r <= NUM_STAGES; r++) begin : g_rank
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    if (r == 0) begin : g_head
      assign up_valid = input_valid;
      assign up_data  = x;
    end else begin : g_body
      assign up_valid = rank_valid[r-1];
      assign up_data  = stage_out[r-1];
    end

    // Rank register: advances only when ready; data holds across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (rdy[r]) begin
        valid_q <= up_valid;
        if (up_valid) begin
          data_q <= up_data;
        end
      end
    end

    assign rank_valid[r] = valid_q;
    assign rank_data[r]  = data_q;
  end

  assign input_ready = rdy[0];
  assign out_valid   = rank_valid[NUM_STAGES];
  assign out         = rank_data[NUM_STAGES];
  assign busy        = |rank_valid;

endmodule
